// File: rtl/apb2axi_sync_fifo.sv
// rtl/apb2axi_sync_fifo.sv - parametrised single-clock valid/ready FIFO with occupancy, watermark, peak monitor and flush
module apb2axi_sync_fifo #(
    parameter int ENTRY_WIDTH  = 64,
    parameter int DEPTH        = 4,
    parameter int AFULL_THRESH = DEPTH - 1,
    parameter int CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   flush,
    input  logic                   push_valid,
    output logic                   push_ready,
    input  logic [ENTRY_WIDTH-1:0] push_data,
    output logic                   pop_valid,
    input  logic                   pop_ready,
    output logic [ENTRY_WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0]       count,
    output logic                   almost_full,
    output logic [CNT_W-1:0]       peak_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(AFULL_THRESH);

    logic [ENTRY_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]       wptr;
    logic [PTR_W-1:0]       rptr;
    logic [CNT_W-1:0]       count_nxt;
    logic [CNT_W-1:0]       peak_nxt;
    logic                   push_hs;
    logic                   pop_hs;

    // Flags come from the count register only, so ready/valid never loop through.
    assign push_ready  = (count != DEPTH_C);
    assign pop_valid   = (count != '0);
    assign almost_full = (count >= AFULL_C);
    assign pop_data    = mem[rptr];

    assign push_hs = push_valid && push_ready;
    assign pop_hs  = pop_valid && pop_ready;

    always_comb begin
        count_nxt = count;
        if (push_hs && !pop_hs) begin
            count_nxt = count + CNT_W'(1);
        end else if (pop_hs && !push_hs) begin
            count_nxt = count - CNT_W'(1);
        end
        peak_nxt = (count_nxt > peak_count) ? count_nxt : peak_count;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            peak_count <= '0;
        end else if (flush) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            peak_count <= '0;
        end else begin
            if (push_hs) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop_hs) begin
                rptr <= rptr + PTR_W'(1);
            end
            count      <= count_nxt;
            peak_count <= peak_nxt;
        end
    end

    // Storage is left intact by flush; only reset zeroes it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push_hs && !flush) begin
            mem[wptr] <= push_data;
        end
    end

endmodule
